// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- data-memory access stage of the pipeline.
//
// Converts a load/store sitting in the MEM stage into a request on a simple
// request/grant + read-valid data bus, stalls the upstream pipeline while the
// access is outstanding, and returns the size/sign-extended load result.
//
// Handshake summary (one place, applies to every bus signal below):
//   - The request phase is dReq/dGnt: the request is transferred in the cycle
//     where dReq=1 and dGnt=1. While dReq=1 and dGnt=0, dWe/dAddr/dBe/dWdata
//     are held stable.
//   - The read-data phase is dRvalid alone: it is only looked at while a
//     granted load is waiting for data, and is ignored at any other time.
//   - dGnt with no request pending is ignored.
//   - A stalled pipeline (stallReq=1) keeps all mem* inputs stable.
//
// Ports
//   clk, arstn                 clock (rising edge), async active-low reset
//   memLoad, memStore          access kind in MEM (both high = store)
//   memFunct3                  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//                              (011/110/111 behave as W)
//   memAddr, memStoreData      effective address, LSB-aligned store data
//   dReq, dWe, dAddr, dBe,
//   dWdata                     bus request, write flag, word address, byte
//                              enables, lane-replicated write data
//   dGnt, dRvalid, dRdata      bus grant, read data valid, read data
//   stallReq                   freeze IF..EX/MEM, access not done this cycle
//   loadData, loadValid        extended load result / load completes now
//   misalignErr, busErr        one-cycle error pulses
//   dbg_state                  current FSM state (0 IDLE, 1 WAIT_GNT,
//                              2 WAIT_RVALID)
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int unsigned BUS_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        arstn,
  input  logic        memLoad,
  input  logic        memStore,
  input  logic [2:0]  memFunct3,
  input  logic [31:0] memAddr,
  input  logic [31:0] memStoreData,
  output logic        dReq,
  output logic        dWe,
  output logic [31:0] dAddr,
  output logic [3:0]  dBe,
  output logic [31:0] dWdata,
  input  logic        dGnt,
  input  logic        dRvalid,
  input  logic [31:0] dRdata,
  output logic        stallReq,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        misalignErr,
  output logic        busErr,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_GNT    = 2'd1,
    ST_WAIT_RVALID = 2'd2
  } state_t;

  // The wait counter is zero in the first cycle after the request cycle, so
  // the access is (wait_cnt + 1) cycles old; it has reached cycle
  // BUS_TIMEOUT-1 when wait_cnt equals BUS_TIMEOUT-2.
  localparam logic [7:0] TIMEOUT_CNT = 8'(BUS_TIMEOUT - 2);

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  wait_cnt_q;

  // Access captured in the request cycle, replayed while waiting.
  logic        we_q;
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;

  // Decode of the incoming access.
  logic        acc_req;
  logic        acc_we;
  logic        sz_b;
  logic        sz_h;
  logic        sz_w;
  logic        misaligned;
  logic        idle_issue;
  logic        idle_misalign;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  // Per-cycle outcome of the outstanding access.
  logic        complete;
  logic        timeout_hit;
  logic        abort;

  // Load extraction.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // ---------------------------------------------------------------------------
  // Incoming access decode. Reset gates the request so nothing leaks onto the
  // bus combinationally while arstn is low.
  // ---------------------------------------------------------------------------
  always_comb begin
    acc_req       = arstn & (memLoad | memStore);
    acc_we        = memStore;
    sz_w          = memFunct3[1];
    sz_h          = ~memFunct3[1] & memFunct3[0];
    sz_b          = ~memFunct3[1] & ~memFunct3[0];
    misaligned    = (sz_h & memAddr[0]) | (sz_w & (memAddr[1:0] != 2'b00));
    idle_misalign = (state_q == ST_IDLE) & acc_req & misaligned;
    idle_issue    = (state_q == ST_IDLE) & acc_req & ~misaligned;

    be_c    = 4'b1111;
    wdata_c = memStoreData;
    if (sz_b) begin
      be_c    = 4'b0001 << memAddr[1:0];
      wdata_c = {4{memStoreData[7:0]}};
    end else if (sz_h) begin
      be_c    = 4'b0011 << memAddr[1:0];
      wdata_c = {2{memStoreData[15:0]}};
    end
  end

  // ---------------------------------------------------------------------------
  // Completion / timeout. A cycle that completes the access never times out;
  // a load granted in its timeout cycle has not completed and is aborted.
  // ---------------------------------------------------------------------------
  always_comb begin
    complete = 1'b0;
    case (state_q)
      ST_IDLE:        complete = idle_issue & acc_we & dGnt;
      ST_WAIT_GNT:    complete = we_q & dGnt;
      ST_WAIT_RVALID: complete = dRvalid;
      default:        complete = 1'b0;
    endcase
    timeout_hit = (state_q != ST_IDLE) && (wait_cnt_q == TIMEOUT_CNT);
    abort       = timeout_hit & ~complete;
  end

  // ---------------------------------------------------------------------------
  // FSM: state register.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (idle_issue) begin
          if (dGnt) begin
            state_d = acc_we ? ST_IDLE : ST_WAIT_RVALID;
          end else begin
            state_d = ST_WAIT_GNT;
          end
        end
      end
      ST_WAIT_GNT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (dGnt) begin
          state_d = we_q ? ST_IDLE : ST_WAIT_RVALID;
        end
      end
      ST_WAIT_RVALID: begin
        if (dRvalid || abort) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. In the request cycle the bus sees the decoded inputs
  // directly; afterwards it sees the captured copy.
  // ---------------------------------------------------------------------------
  always_comb begin
    dReq        = idle_issue | ((state_q == ST_WAIT_GNT) & ~abort);
    dWe         = 1'b0;
    dBe         = 4'b0000;
    if (dReq) begin
      dWe = (state_q == ST_IDLE) ? acc_we : we_q;
      dBe = (state_q == ST_IDLE) ? be_c   : be_q;
    end
    dAddr       = idle_issue ? {memAddr[31:2], 2'b00} : addr_q;
    dWdata      = idle_issue ? wdata_c : wdata_q;
    stallReq    = (idle_issue | (state_q != ST_IDLE)) & ~complete & ~abort;
    loadValid   = (state_q == ST_WAIT_RVALID) & dRvalid;
    loadData    = loadValid ? ld_ext : 32'h0;
    misalignErr = idle_misalign;
    busErr      = abort;
    dbg_state   = state_q;
  end

  // ---------------------------------------------------------------------------
  // Wait counter: zero while idle and on return to idle, counts wait cycles.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      wait_cnt_q <= 8'd0;
    end else if (state_q == ST_IDLE || state_d == ST_IDLE) begin
      wait_cnt_q <= 8'd0;
    end else begin
      wait_cnt_q <= wait_cnt_q + 8'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Access capture in the request cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      f3_q    <= 3'h0;
      off_q   <= 2'h0;
    end else if (idle_issue) begin
      we_q    <= acc_we;
      addr_q  <= {memAddr[31:2], 2'b00};
      be_q    <= be_c;
      wdata_q <= wdata_c;
      f3_q    <= memFunct3;
      off_q   <= memAddr[1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the captured offset and size/sign.
  // ---------------------------------------------------------------------------
  always_comb begin
    case (off_q)
      2'd0:    ld_byte = dRdata[7:0];
      2'd1:    ld_byte = dRdata[15:8];
      2'd2:    ld_byte = dRdata[23:16];
      default: ld_byte = dRdata[31:24];
    endcase
    ld_half = off_q[1] ? dRdata[31:16] : dRdata[15:0];

    if (f3_q[1]) begin
      ld_ext = dRdata;
    end else if (f3_q[0]) begin
      ld_ext = f3_q[2] ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
    end else begin
      ld_ext = f3_q[2] ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: BUS_TIMEOUT, 16, cycles an access may wait for dGnt or dRvalid before abort; legal range 2..255.
REQ-002 clk  in  1  clock, rising edge.
REQ-003 arstn  in  1  reset, asynchronous, active-low.
REQ-004 memLoad  in  1  load in MEM stage.
REQ-005 memStore  in  1  store in MEM stage.
REQ-006 memFunct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-007 memAddr  in  32  effective address, from EX/MEM rdWriteData.
REQ-008 memStoreData  in  32  store operand, LSB-aligned.
REQ-009 dReq  out  1  data-bus request.
REQ-010 dWe  out  1  1 = write.
REQ-011 dAddr  out  32  word address, memAddr with [1:0]=00.
REQ-012 dBe  out  4  byte enables.
REQ-013 dWdata  out  32  lane-replicated write data.
REQ-014 dGnt  in  1  bus accepts request this cycle.
REQ-015 dRvalid  in  1  read data valid.
REQ-016 dRdata  in  32  read data.
REQ-017 stallReq  out  1  freeze IF..EX/MEM; access not complete this cycle.
REQ-018 loadData  out  32  extended load result, valid when loadValid.
REQ-019 loadValid  out  1  load completes this cycle.
REQ-020 misalignErr  out  1  one-cycle pulse, misaligned access rejected.
REQ-021 busErr  out  1  one-cycle pulse, bus timeout.

Function
REQ-022 FSM states IDLE, WAIT_GNT, WAIT_RVALID; memLoad and memStore both high is treated as a store; funct3 011/110/111 is treated as W.
REQ-023 Misaligned = H/HU with addr[0]=1, or W with addr[1:0]!=00; in IDLE this asserts misalignErr combinationally, no dReq, no stall, and stays in IDLE.
REQ-024 In IDLE, an aligned access drives dReq=1 combinationally the same cycle and registers dWe, dAddr, dBe, dWdata, funct3 and addr[1:0] for the following cycles.
REQ-025 dBe: B = 0001<<addr[1:0]; H = 0011<<addr[1:0]; W = 1111; dWdata: B = {4{data[7:0]}}; H = {2{data[15:0]}}; W = data.
REQ-026 Store with dGnt in the request cycle completes with zero stall; without dGnt -> WAIT_GNT.
REQ-027 Load with dGnt -> WAIT_RVALID; without dGnt -> WAIT_GNT.
REQ-028 WAIT_GNT holds dReq=1 with stable registered bus outputs until dGnt; then store -> IDLE, load -> WAIT_RVALID.
REQ-029 In WAIT_RVALID dReq=0; dRvalid=1 gives loadValid=1 combinationally and the next state is IDLE.
REQ-030 loadData uses the byte/half selected by the registered offset; B/H sign-extend, BU/HU zero-extend, W passes through; loadData=0 when loadValid=0.
REQ-031 stallReq=1 in IDLE for an aligned access not completing that cycle, in WAIT_GNT, and in WAIT_RVALID unless dRvalid=1; upstream holds all mem* inputs stable while stalled.
REQ-032 An 8-bit wait counter clears on IDLE exit and increments each cycle in WAIT_GNT/WAIT_RVALID; reaching BUS_TIMEOUT-1 without completion pulses busErr, drops dReq, forces IDLE, releases stall, and gives loadValid=0.
REQ-033 dRvalid or dGnt arriving while in IDLE with no access is ignored.
REQ-034 A new access is accepted in the cycle after completion, with no bubble required.

Reset
REQ-035 arstn low forces IDLE immediately; dReq, dWe, dBe, stallReq, loadValid, misalignErr, busErr = 0; dAddr, dWdata, loadData, counter = 0.
REQ-036 Reset mid-access abandons the transaction; a late dRvalid after reset is ignored.

Verification
REQ-037 SW addr 0x100, data 0xDEADBEEF, dGnt same cycle -> dReq=1, dWe=1, dBe=1111, dAddr=0x100, stallReq=0, state stays IDLE.
REQ-038 LB addr 0x203, dGnt at cycle 0, dRvalid at cycle 2 with dRdata 0x80FFFFFF -> stallReq high for cycles 0-1, loadValid at cycle 2, loadData=0xFFFFFF80.
REQ-039 SH addr 0x302 data 0x0000ABCD, dGnt delayed 3 cycles -> dBe=1100, dWdata=0xABCDABCD stable, stallReq high 3 cycles.
REQ-040 LW addr 0x101 -> misalignErr pulse, dReq=0, stallReq=0; LHU addr 0x102 with dRdata 0x8001xxxx -> loadData=0x00008001.
REQ-041 LW with dGnt never asserted, BUS_TIMEOUT=16 -> busErr pulse in cycle 15, dReq drops, stallReq=0 in cycle 15.
REQ-042 arstn asserted in WAIT_RVALID, then dRvalid -> loadValid stays 0, all outputs at reset values.
